// File: rtl/cci_mpf_shim_req_arb.sv
// Shares one CCI c0/c1 request path among N_REQ requesters: per-requester FIFOs,
// round-robin merge with requester-index mdata tags, and tag-steered responses.

module cci_mpf_shim_req_arb_chan #(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned PW             = 64,
  parameter int unsigned MDATA_W        = 16,
  parameter int unsigned TAG_W          = 3,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned ALM_FULL_SLACK = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         rq_valid,
  input  logic [N_REQ*PW-1:0]      rq_hdr,
  input  logic [N_REQ*MDATA_W-1:0] rq_mdata,
  output logic [N_REQ-1:0]         rq_alm_full,
  input  logic                     tx_alm_full,
  output logic                     tx_valid,
  output logic [PW-1:0]            tx_hdr,
  output logic [MDATA_W-1:0]       tx_mdata
);
  localparam int unsigned LOW_W = MDATA_W - TAG_W;
  localparam int unsigned EW    = PW + LOW_W;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(FIFO_DEPTH - ALM_FULL_SLACK);
  localparam logic [IDX_W:0]   N_CNT    = (IDX_W + 1)'(N_REQ);

  logic [EW-1:0]    mem     [N_REQ][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr  [N_REQ];
  logic [PTR_W-1:0] rd_ptr  [N_REQ];
  logic [CNT_W-1:0] cnt     [N_REQ];
  logic [CNT_W-1:0] cnt_nxt [N_REQ];
  logic [EW-1:0]    entry   [N_REQ];
  logic [N_REQ-1:0] nonempty, enq, deq, ovf, rot;
  logic [IDX_W-1:0] rr, gnt;
  logic [IDX_W:0]   ofs, sum;
  logic [EW-1:0]    head;
  logic             gnt_valid;
  logic             unused_tag;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) nonempty[i] = (cnt[i] != '0);
  end

  // Rotate the non-empty mask so the first set bit is the next requester at/after rr.
  always_comb begin
    rot       = N_REQ'({nonempty, nonempty} >> rr);
    gnt_valid = 1'b0;
    ofs       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        gnt_valid = 1'b1;
        ofs       = (IDX_W + 1)'(k);
      end
    end
    if (tx_alm_full) gnt_valid = 1'b0;
    sum = {1'b0, rr} + ofs;
    gnt = (sum >= N_CNT) ? IDX_W'(sum - N_CNT) : IDX_W'(sum);
  end

  // A full FIFO still accepts a write when the same edge drains it.
  always_comb begin
    unused_tag = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      deq[i]     = gnt_valid && (gnt == IDX_W'(i));
      enq[i]     = rq_valid[i] && ((cnt[i] != FULL_CNT) || deq[i]);
      ovf[i]     = rq_valid[i] && !enq[i];
      cnt_nxt[i] = cnt[i] + CNT_W'(enq[i]) - CNT_W'(deq[i]);
      entry[i]   = {rq_hdr[i*PW +: PW], rq_mdata[i*MDATA_W +: LOW_W]};
      unused_tag = unused_tag ^ (^rq_mdata[i*MDATA_W+LOW_W +: TAG_W]);
    end
    head = mem[gnt][rd_ptr[gnt]];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (enq[i]) mem[i][wr_ptr[i]] <= entry[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
      rq_alm_full <= '0;
      rr          <= '0;
      tx_valid    <= 1'b0;
      tx_hdr      <= '0;
      tx_mdata    <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (enq[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (deq[i]) rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        cnt[i]         <= cnt_nxt[i];
        rq_alm_full[i] <= (cnt_nxt[i] >= AF_CNT);
      end
      tx_valid <= gnt_valid;
      if (gnt_valid) begin
        rr       <= (gnt == IDX_W'(N_REQ - 1)) ? '0 : gnt + IDX_W'(1);
        tx_hdr   <= head[EW-1:LOW_W];
        tx_mdata <= {TAG_W'(gnt), head[LOW_W-1:0]};
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) ovf == '0);
endmodule

module cci_mpf_shim_req_arb #(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned C0_W           = 64,
  parameter int unsigned C1_W           = 640,
  parameter int unsigned MDATA_W        = 16,
  parameter int unsigned TAG_W          = 3,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned ALM_FULL_SLACK = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         rq_c0_valid,
  input  logic [N_REQ*C0_W-1:0]    rq_c0_hdr,
  input  logic [N_REQ*MDATA_W-1:0] rq_c0_mdata,
  output logic [N_REQ-1:0]         rq_c0_almFull,
  input  logic [N_REQ-1:0]         rq_c1_valid,
  input  logic [N_REQ*C1_W-1:0]    rq_c1_hdr,
  input  logic [N_REQ*MDATA_W-1:0] rq_c1_mdata,
  output logic [N_REQ-1:0]         rq_c1_almFull,
  output logic                     c0Tx_valid,
  output logic [C0_W-1:0]          c0Tx_hdr,
  output logic [MDATA_W-1:0]       c0Tx_mdata,
  input  logic                     c0TxAlmFull,
  output logic                     c1Tx_valid,
  output logic [C1_W-1:0]          c1Tx_hdr,
  output logic [MDATA_W-1:0]       c1Tx_mdata,
  input  logic                     c1TxAlmFull,
  input  logic                     c0Rx_valid,
  input  logic [MDATA_W-1:0]       c0Rx_mdata,
  input  logic                     c1Rx_valid,
  input  logic [MDATA_W-1:0]       c1Rx_mdata,
  output logic [N_REQ-1:0]         rs_c0_valid,
  output logic [N_REQ-1:0]         rs_c1_valid,
  output logic [MDATA_W-1:0]       rs_c0_mdata,
  output logic [MDATA_W-1:0]       rs_c1_mdata
);
  localparam int unsigned LOW_W = MDATA_W - TAG_W;
  localparam logic [TAG_W:0] N_TAG = (TAG_W + 1)'(N_REQ);

  logic [TAG_W-1:0] c0_tag, c1_tag;

  assign c0_tag = c0Rx_mdata[MDATA_W-1:LOW_W];
  assign c1_tag = c1Rx_mdata[MDATA_W-1:LOW_W];

  cci_mpf_shim_req_arb_chan #(
    .N_REQ(N_REQ), .PW(C0_W), .MDATA_W(MDATA_W), .TAG_W(TAG_W),
    .FIFO_DEPTH(FIFO_DEPTH), .ALM_FULL_SLACK(ALM_FULL_SLACK)
  ) u_c0 (
    .clk(clk), .reset(reset),
    .rq_valid(rq_c0_valid), .rq_hdr(rq_c0_hdr), .rq_mdata(rq_c0_mdata),
    .rq_alm_full(rq_c0_almFull), .tx_alm_full(c0TxAlmFull),
    .tx_valid(c0Tx_valid), .tx_hdr(c0Tx_hdr), .tx_mdata(c0Tx_mdata)
  );

  cci_mpf_shim_req_arb_chan #(
    .N_REQ(N_REQ), .PW(C1_W), .MDATA_W(MDATA_W), .TAG_W(TAG_W),
    .FIFO_DEPTH(FIFO_DEPTH), .ALM_FULL_SLACK(ALM_FULL_SLACK)
  ) u_c1 (
    .clk(clk), .reset(reset),
    .rq_valid(rq_c1_valid), .rq_hdr(rq_c1_hdr), .rq_mdata(rq_c1_mdata),
    .rq_alm_full(rq_c1_almFull), .tx_alm_full(c1TxAlmFull),
    .tx_valid(c1Tx_valid), .tx_hdr(c1Tx_hdr), .tx_mdata(c1Tx_mdata)
  );

  // Responses are steered purely by their tag; no arbiter state is consulted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_c0_valid <= '0;
      rs_c1_valid <= '0;
      rs_c0_mdata <= '0;
      rs_c1_mdata <= '0;
    end else begin
      for (int t = 0; t < N_REQ; t++) begin
        rs_c0_valid[t] <= c0Rx_valid && (c0_tag == TAG_W'(t));
        rs_c1_valid[t] <= c1Rx_valid && (c1_tag == TAG_W'(t));
      end
      rs_c0_mdata <= {{TAG_W{1'b0}}, c0Rx_mdata[LOW_W-1:0]};
      rs_c1_mdata <= {{TAG_W{1'b0}}, c1Rx_mdata[LOW_W-1:0]};
    end
  end

  a_c0_tag_ok: assert property (@(posedge clk) disable iff (reset)
                                !(c0Rx_valid && ({1'b0, c0_tag} >= N_TAG)));
  a_c1_tag_ok: assert property (@(posedge clk) disable iff (reset)
                                !(c1Rx_valid && ({1'b0, c1_tag} >= N_TAG)));
endmodule
